// File: rtl/xintf_pkg.sv
// Shared constants and write-FSM encoding for the XINTF register bank.
package xintf_pkg;

  localparam int          AW_DEF        = 14;
  localparam int          DW_DEF        = 16;
  localparam logic [13:0] BASE_OUT_DEF  = 14'h0010;
  localparam logic [13:0] ADDR_FST_DEF  = 14'h0020;
  localparam logic [13:0] ADDR_FMSK_DEF = 14'h0021;
  localparam logic [13:0] ADDR_FRAW_DEF = 14'h0022;
  localparam logic [13:0] ADDR_ID_DEF   = 14'h0023;
  localparam logic [15:0] ID_VAL_DEF    = 16'hC0C1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAPT   = 2'd1,
    COMMIT = 2'd2
  } wr_state_e;

endpackage

// File: rtl/xintf_sync.sv
// Two-flop synchroniser for async pins; output lags the pin by 2 CLK.
// No flow control; reset forces both stages to RST_VAL (the inactive level).
module xintf_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q_out
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/xintf_reg_bank.sv
// DSP XINTF register bank: control registers, sticky/masked faults, fault interrupt.
// A write lands 4 CLK after WEn rises; reads are registered, 2 CLK sync + 1 CLK mux.
module xintf_reg_bank
  import xintf_pkg::*;
#(
  parameter int              AW        = AW_DEF,
  parameter int              DW        = DW_DEF,
  parameter int              N_OUT     = 4,
  parameter int              N_FAULT   = 8,
  parameter logic [AW-1:0]   BASE_OUT  = AW'(BASE_OUT_DEF),
  parameter logic [AW-1:0]   ADDR_FST  = AW'(ADDR_FST_DEF),
  parameter logic [AW-1:0]   ADDR_FMSK = AW'(ADDR_FMSK_DEF),
  parameter logic [AW-1:0]   ADDR_FRAW = AW'(ADDR_FRAW_DEF),
  parameter logic [AW-1:0]   ADDR_ID   = AW'(ADDR_ID_DEF),
  parameter logic [DW-1:0]   ID_VAL    = DW'(ID_VAL_DEF)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [AW-1:0]       Addr,
  input  logic [DW-1:0]       Data_in,
  output logic [DW-1:0]       Data_out,
  output logic                Data_oe,
  input  logic                CSn,
  input  logic                WEn,
  input  logic                OEn,
  output logic [N_OUT*DW-1:0] OUT_REGS,
  input  logic [N_FAULT-1:0]  FAULT_IN,
  output logic                FAULT_XINT,
  output logic                wr_pulse
);

  localparam logic [AW:0] OUT_FIRST = {1'b0, BASE_OUT};
  localparam logic [AW:0] OUT_LAST  = {1'b0, BASE_OUT} + (AW+1)'(N_OUT - 1);

  function automatic bit in_out_window(input logic [AW-1:0] a);
    return ({1'b0, a} >= OUT_FIRST) && ({1'b0, a} <= OUT_LAST);
  endfunction

  localparam bit OVERLAP = in_out_window(ADDR_FST) || in_out_window(ADDR_FMSK) ||
                           in_out_window(ADDR_FRAW) || in_out_window(ADDR_ID);

  if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
    $error("xintf_reg_bank: N_OUT must be 1..16");
  end
  if (N_FAULT < 1 || N_FAULT > DW) begin : g_bad_n_fault
    $error("xintf_reg_bank: N_FAULT must be 1..DW");
  end
  if (OVERLAP) begin : g_bad_map
    $error("xintf_reg_bank: output register window overlaps fault/ID addresses");
  end

  logic [2:0]         s_strb;
  logic               s_csn, s_wen, s_oen;
  logic [N_FAULT-1:0] s_fault;

  xintf_sync #(.W(3), .RST_VAL(3'b111)) u_sync_strb (
    .CLK   (CLK),
    .RESET (RESET),
    .d_in  ({CSn, WEn, OEn}),
    .q_out (s_strb)
  );

  xintf_sync #(.W(N_FAULT), .RST_VAL({N_FAULT{1'b1}})) u_sync_fault (
    .CLK   (CLK),
    .RESET (RESET),
    .d_in  (FAULT_IN),
    .q_out (s_fault)
  );

  assign {s_csn, s_wen, s_oen} = s_strb;

  wr_state_e     state_q, state_d;
  logic [AW-1:0] cap_addr_q, cap_addr_d;
  logic [DW-1:0] cap_dat_q, cap_dat_d;
  logic          commit;

  // Entering CAPT implies s_wen was low, so s_wen high in CAPT is the rising edge.
  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    cap_dat_d  = cap_dat_q;
    case (state_q)
      IDLE: begin
        if (!s_csn && !s_wen) state_d = CAPT;
      end
      CAPT: begin
        cap_addr_d = Addr;
        cap_dat_d  = Data_in;
        if (s_wen)      state_d = COMMIT;
        else if (s_csn) state_d = IDLE;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign commit = (state_q == COMMIT);

  logic [DW-1:0]      out_q [N_OUT];
  logic [DW-1:0]      out_d [N_OUT];
  logic [N_FAULT-1:0] mask_q, mask_d;
  logic [N_FAULT-1:0] sticky_q, sticky_d;
  logic [N_FAULT-1:0] w1c;
  logic               xint_q, xint_d;
  logic               wr_pulse_q, wr_pulse_d;
  logic [DW-1:0]      data_out_q, data_out_d;
  logic [DW-1:0]      rd_mux;
  logic               hit_fst, hit_fmsk;

  assign hit_fst  = commit && (cap_addr_q == ADDR_FST);
  assign hit_fmsk = commit && (cap_addr_q == ADDR_FMSK);

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      out_d[i] = out_q[i];
      if (commit && (cap_addr_q == BASE_OUT + AW'(i))) out_d[i] = cap_dat_q;
    end
  end

  // A fault present in the same cycle as its W1C keeps the bit set.
  always_comb begin
    w1c        = hit_fst ? cap_dat_q[N_FAULT-1:0] : '0;
    sticky_d   = (sticky_q & ~w1c) | ~s_fault;
    mask_d     = hit_fmsk ? cap_dat_q[N_FAULT-1:0] : mask_q;
    xint_d     = ~|(sticky_q & mask_q);
    wr_pulse_d = commit;
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (Addr == BASE_OUT + AW'(i)) rd_mux = out_q[i];
    end
    if (Addr == ADDR_FST)  rd_mux = DW'(sticky_q);
    if (Addr == ADDR_FMSK) rd_mux = DW'(mask_q);
    if (Addr == ADDR_FRAW) rd_mux = DW'(s_fault);
    if (Addr == ADDR_ID)   rd_mux = ID_VAL;
    data_out_d = (!s_csn && !s_oen) ? rd_mux : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cap_addr_q <= '0;
      cap_dat_q  <= '0;
      mask_q     <= '1;
      sticky_q   <= '0;
      xint_q     <= 1'b1;
      wr_pulse_q <= 1'b0;
      data_out_q <= '0;
      for (int i = 0; i < N_OUT; i++) out_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
      cap_dat_q  <= cap_dat_d;
      mask_q     <= mask_d;
      sticky_q   <= sticky_d;
      xint_q     <= xint_d;
      wr_pulse_q <= wr_pulse_d;
      data_out_q <= data_out_d;
      for (int i = 0; i < N_OUT; i++) out_q[i] <= out_d[i];
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out_flat
    assign OUT_REGS[g*DW +: DW] = out_q[g];
  end

  assign Data_oe    = !CSn && !OEn;
  assign Data_out   = data_out_q;
  assign FAULT_XINT = xint_q;
  assign wr_pulse   = wr_pulse_q;

endmodule
